// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
// Declares the FSM state enum and the counter width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2,
    ST_FIN     = 2'd3
  } state_e;

  localparam int unsigned DEF_N_OUT    = 4;
  localparam int unsigned DEF_HOLD_CYC = 8;
  localparam int unsigned DEF_GAP_CYC  = 2;

  // The counter has to reach the terminal value itself, so it needs room for max+1 codes.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Soft-reset request and sequenced reset outputs of rst_seq.
// req is level-sampled on every rising edge; all other signals are registered by the slave.
interface rst_seq_if #(
  parameter int unsigned N_OUT = rst_seq_pkg::DEF_N_OUT
);
  import rst_seq_pkg::*;

  logic             req;
  logic [N_OUT-1:0] rst_n_out;
  logic             busy;
  logic             done;
  state_e           dbg_state;

  modport master (output req, input rst_n_out, busy, done, dbg_state);
  modport slave  (input req, output rst_n_out, busy, done, dbg_state);

endinterface

// File: rtl/rst_seq_cnt.sv
// Shared hold/gap counter: clears on rst, loads 1, counts up, flags the terminal count.
// Loading 1 (not 0) makes the edge that loads it count as the first cycle of the interval.
module rst_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic         hit
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(1);
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = (count_q == tc);

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all downstream resets low, then releases them one by one
// in index order, pulses done, and idles until the next req or block reset.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_OUT    = DEF_N_OUT,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC
) (
  input logic      clk,
  input logic      rst,
  rst_seq_if.slave bus
);

  localparam int unsigned   CW       = cnt_width(HOLD_CYC, GAP_CYC);
  localparam int unsigned   IW       = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_OUT - 1);
  localparam logic [CW-1:0] HOLD_TC  = CW'(HOLD_CYC);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYC);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_OUT-1:0] rst_n_q, rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_load, cnt_en, cnt_hit;
  logic [CW-1:0]    cnt_tc;

  assign cnt_tc = (state_q == ST_ASSERT) ? HOLD_TC : GAP_TC;

  rst_seq_cnt #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .tc   (cnt_tc),
    .hit  (cnt_hit)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rst_n_d  = rst_n_q;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    // A request wins in every state, including FIN where it suppresses done.
    if (bus.req) begin
      state_d  = ST_ASSERT;
      idx_d    = '0;
      rst_n_d  = '0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
        end
        ST_ASSERT, ST_RELEASE: begin
          if (cnt_hit) begin
            cnt_load       = 1'b1;
            rst_n_d[idx_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
              state_d = ST_FIN;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = idx_q + IW'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_FIN: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: begin
          state_d = ST_ASSERT;
          rst_n_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule
